fifo_frame_packer: RTL and testbench
====================================

# fifo_frame_packer

Drains 32-bit words from the read side of the dual-clock `fifo` and emits length-prefixed frames: one header word, 1..FRAME_WORDS payload words, one XOR-checksum trailer. Sits directly downstream of `fifo` in the `clock_out` domain; its `fifo_*` ports connect to `data_out` / `data_out_valid` / `data_out_ack`. Payload is buffered internally so the header carries the true length even when a frame is closed early by `flush`.

## Interface
- `DATA_WIDTH`, 32, word width; must be ≥ 32.
- `FRAME_WORDS`, 8, maximum payload words per frame; legal range 1..255.
- `SEQ_WIDTH`, 16, frame sequence counter width; fixed at 16 for the header layout.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  DATA_WIDTH  head word of upstream `fifo`; stable while `fifo_valid` is high and not acked.
- `fifo_valid`  in  1  head word present.
- `fifo_ack`  out  1  pop strobe; word consumed on a cycle where `fifo_valid && fifo_ack`.
- `flush`  in  1  close the current partial frame.
- `frame_data`  out  DATA_WIDTH  frame word.
- `frame_valid`  out  1  `frame_data` valid.
- `frame_ready`  in  1  sink accepts; transfer on `frame_valid && frame_ready`.
- `frame_sop`  out  1  high with header word.
- `frame_eop`  out  1  high with trailer word.

## Operation
- FSM states: FILL, HDR, PAY, TRL. Reset state FILL.
- FILL: `fifo_ack = fifo_valid && (count < FRAME_WORDS)`, combinational. Each pop writes `fifo_data` into buffer[count], count++, `csum ^= fifo_data`.
- FILL→HDR when a pop makes count == FRAME_WORDS, or `flush` sampled high with (count + pop this cycle) > 0. A word popped in the same cycle as `flush` is included. `flush` with empty buffer and no pop: ignored.
- HDR: `frame_data` = zero-extended {8'hA5, seq[15:0], len[7:0]}, len = count; `frame_sop` = 1. On transfer → PAY, rd_idx = 0.
- PAY: `frame_data` = buffer[rd_idx]. On transfer rd_idx++; after rd_idx == len−1 transfers → TRL.
- TRL: `frame_data` = csum (XOR of all payload words, full DATA_WIDTH); `frame_eop` = 1. On transfer → FILL; count, csum cleared; seq++ modulo 2^16 (0xFFFF → 0x0000).
- `fifo_ack` is 0 in HDR/PAY/TRL; no overlap of fill and drain.
- `frame_valid` = (state != FILL); stays high, `frame_data` stable, until transfer. `frame_ready` ignored when `frame_valid` is low.
- `rst` asserted at any point: immediately state FILL, count 0, csum 0, seq 0, rd_idx 0; buffered words and any partial frame discarded.

## Timing
- Reset values: `fifo_ack` 0 (with `fifo_valid` 0), `frame_valid` 0, `frame_sop` 0, `frame_eop` 0, `frame_data` 0.
- `frame_data` in FILL is driven 0.
- Fill latency: one cycle per word with `fifo_valid` continuously high; `frame_valid` rises the cycle after the last pop or the `flush` cycle.
- Drain: len+2 cycles with `frame_ready` held high; each low `frame_ready` cycle adds one.
- Back-to-back full frames with both sides always ready: FRAME_WORDS + (FRAME_WORDS+2) cycles per frame.
- `frame_sop`/`frame_eop` are never high in the same cycle (len ≥ 1 always).

## Structure
- Shared defines header `fifo_frame_defs.vh`: SYNC byte 8'hA5, state encodings, header field offsets/widths (SYNC [31:24], SEQ [23:8], LEN [7:0]).
- Sub-module `fifo_frame_buf`: FRAME_WORDS × DATA_WIDTH register array, synchronous write at `wr_idx`, combinational read at `rd_idx`, no reset on storage.
- Top holds FSM, count, rd_idx, csum, seq.

## Test plan
- Full frame: push 1,2,4,…,0x80 (8 words), `frame_ready`=1 → header 0xA5000008, payload 0x01..0x80 in order, trailer 0x000000FF, seq 0.
- Flush: push 0x11, 0x22, 0x33 then `flush` → header 0xA5000003, trailer 0x00000000; second frame header 0xA5000103.
- Backpressure: full frame, `frame_ready` toggled 1-0-0-1 → each word held stable while not accepted; no `fifo_ack` during drain; no words lost or duplicated.
- Flush on empty buffer, and flush in same cycle as the first pop → first ignored; second emits len 1 frame with that word.
- Seq wrap: force 65537 one-word frames → header SEQ field runs 0xFFFF then 0x0000.
- Reset mid-PAY after 3 of 8 words accepted → outputs 0 immediately; next frame header 0xA5000008 with seq 0, prior buffer contents absent.

Source files
------------

// File: rtl/fifo_frame_packer_pkg.sv
// Shared constants for the frame packer: sync byte, header field layout,
// FSM state encodings and a header builder.
package fifo_frame_packer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Header layout: SYNC [31:24], SEQ [23:8], LEN [7:0]
    localparam int SYNC_LSB = 24;
    localparam int SYNC_W   = 8;
    localparam int SEQ_LSB  = 8;
    localparam int SEQ_W    = 16;
    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 8;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_TRL  = 2'd3;

    function automatic logic [31:0] make_header(input logic [SEQ_W-1:0] seq,
                                                input logic [LEN_W-1:0] len);
        logic [31:0] hdr;
        hdr = '0;
        hdr[SYNC_LSB +: SYNC_W] = SYNC_BYTE;
        hdr[SEQ_LSB  +: SEQ_W]  = seq;
        hdr[LEN_LSB  +: LEN_W]  = len;
        return hdr;
    endfunction

endpackage

// File: rtl/fifo_frame_buf.sv
// Payload buffer: FRAME_WORDS x DATA_WIDTH register array.
// Ports: clock, wr_en/wr_idx/wr_data (synchronous write),
//        rd_idx -> rd_data (combinational read). Storage is not reset.
module fifo_frame_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = 8,
    parameter int IDX_W       = 3
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FRAME_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_frame_packer.sv
// Frame packer: pops words from the upstream fifo read port, buffers up to
// FRAME_WORDS of them, then emits header / payload / XOR-checksum trailer.
// Ports: clock, rst (async, active high);
//        fifo_data/fifo_valid/fifo_ack  upstream pop interface;
//        flush                          close a partial frame;
//        frame_data/valid/ready/sop/eop downstream frame stream.
//
// state | meaning
// FILL  | popping words into the buffer, accumulating checksum
// HDR   | presenting header word (sync, seq, len)
// PAY   | presenting buffered payload words in order
// TRL   | presenting checksum trailer; on accept return to FILL
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = 8,
    parameter int SEQ_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ack,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_sop,
    output logic                  frame_eop
);

    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FRAME_WORDS);

    logic [1:0]            state;
    logic [LEN_W-1:0]      count;
    logic [LEN_W-1:0]      count_inc;
    logic [LEN_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] csum;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [SEQ_WIDTH-1:0]  seq;
    logic                  pop;
    logic                  close;
    logic                  xfer;

    assign pop       = (state == ST_FILL) && fifo_valid && (count < MAX_LEN);
    assign count_inc = count + {{(LEN_W-1){1'b0}}, pop};
    // A word popped alongside flush belongs to the frame being closed.
    assign close     = (pop && (count_inc == MAX_LEN)) || (flush && (count_inc != '0));
    assign xfer      = frame_valid && frame_ready;
    assign fifo_ack  = pop;

    fifo_frame_buf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_WORDS (FRAME_WORDS),
        .IDX_W       (IDX_W)
    ) u_buf (
        .clock   (clock),
        .wr_en   (pop),
        .wr_idx  (count[IDX_W-1:0]),
        .wr_data (fifo_data),
        .rd_idx  (rd_idx[IDX_W-1:0]),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= ST_FILL;
            count  <= '0;
            rd_idx <= '0;
            csum   <= '0;
            seq    <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (pop) begin
                        csum <= csum ^ fifo_data;
                    end
                    count <= count_inc;
                    if (close) begin
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state  <= ST_PAY;
                        rd_idx <= '0;
                    end
                end
                ST_PAY: begin
                    if (xfer) begin
                        if (rd_idx == count - 1'b1) begin
                            state <= ST_TRL;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (xfer) begin
                        state  <= ST_FILL;
                        count  <= '0;
                        csum   <= '0;
                        rd_idx <= '0;
                        seq    <= seq + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        frame_data  = '0;
        frame_sop   = 1'b0;
        frame_eop   = 1'b0;
        frame_valid = (state != ST_FILL);
        case (state)
            ST_HDR: begin
                frame_data = DATA_WIDTH'(make_header(seq, count));
                frame_sop  = 1'b1;
            end
            ST_PAY: begin
                frame_data = buf_rd_data;
            end
            ST_TRL: begin
                frame_data = csum;
                frame_eop  = 1'b1;
            end
            default: begin
                frame_data = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Scoreboard bench for fifo_frame_packer: a source queue models the upstream
// fifo, expected frame words are queued as frames are composed and popped
// as the DUT transfers them.
module tb_fifo_frame_packer;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_ack;
    logic        flush = 1'b0;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        frame_sop;
    logic        frame_eop;

    fifo_frame_packer #(.DATA_WIDTH(32), .FRAME_WORDS(8), .SEQ_WIDTH(16)) dut (
        .clock       (clock),
        .rst         (rst),
        .fifo_data   (fifo_data),
        .fifo_valid  (fifo_valid),
        .fifo_ack    (fifo_ack),
        .flush       (flush),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_sop   (frame_sop),
        .frame_eop   (frame_eop)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] src_q[$];
    logic [33:0] exp_q[$];
    logic [31:0] frm[$];
    logic [15:0] exp_seq = '0;
    logic        flush_req = 1'b0;
    int          ready_mode = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    logic        hold_valid = 1'b0;
    logic [33:0] hold_word = '0;
    logic        ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        src_q.push_back(w);
        frm.push_back(w);
    endtask

    task automatic close_frame();
        logic [31:0] x;
        x = '0;
        exp_q.push_back({2'b10, 8'hA5, exp_seq, 8'(frm.size())});
        foreach (frm[i]) begin
            exp_q.push_back({2'b00, frm[i]});
            x ^= frm[i];
        end
        exp_q.push_back({2'b01, x});
        exp_seq = exp_seq + 16'd1;
        frm.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (exp_q.size() == 0 && src_q.size() == 0 && !frame_valid) begin
                done = 1'b1;
                break;
            end
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    // Drive on the falling edge, observe settled handshakes 1 ns later.
    always @(negedge clock) begin
        fifo_valid = (src_q.size() > 0);
        fifo_data  = fifo_valid ? src_q[0] : '0;
        flush      = flush_req;
        flush_req  = 1'b0;
        frame_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
        cyc++;
        #1;
        if (!rst) begin
            if (fifo_valid && fifo_ack) void'(src_q.pop_front());
            if (frame_valid) begin
                check_val("no_ack_in_drain", 64'(fifo_ack), 64'd0);
                if (hold_valid)
                    check_val("held_word_stable", 64'({frame_sop, frame_eop, frame_data}), 64'(hold_word));
                if (frame_ready) begin
                    hold_valid = 1'b0;
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_word", 64'({frame_sop, frame_eop, frame_data}), 64'h3_0000_0000);
                    end else begin
                        check_val("frame_word", 64'({frame_sop, frame_eop, frame_data}), 64'(exp_q.pop_front()));
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_word  = {frame_sop, frame_eop, frame_data};
                end
            end
        end
    end

    initial begin
        int base;
        #3;
        check_val("rst_frame_valid", 64'(frame_valid), 64'd0);
        check_val("rst_fifo_ack", 64'(fifo_ack), 64'd0);
        check_val("rst_frame_data", 64'(frame_data), 64'd0);
        check_val("rst_sop_eop", 64'({frame_sop, frame_eop}), 64'd0);
        #20 rst = 1'b0;
        @(posedge clock);

        // Flush closes a 3-word frame; repeat to see seq advance.
        for (int k = 0; k < 2; k++) begin
            add_word(32'h11); add_word(32'h22); add_word(32'h33);
            for (int i = 0; i < 40 && src_q.size() != 0; i++) @(posedge clock);
            flush_req = 1'b1;
            close_frame();
            wait_idle("flush3_done", 60);
        end

        // Full frame of single-bit words.
        for (int i = 0; i < 8; i++) add_word(32'h1 << i);
        close_frame();
        wait_idle("full_done", 80);

        // Backpressure 1-0-0-1.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) add_word(32'hC0DE_0000 + 32'(i * 7));
        close_frame();
        wait_idle("backpressure_done", 120);
        ready_mode = 0;

        // Flush on an empty buffer is ignored.
        flush_req = 1'b1;
        repeat (4) @(posedge clock);
        #2 check_val("empty_flush_ignored", 64'(frame_valid), 64'd0);

        // Flush in the same cycle as the first pop yields a len-1 frame.
        @(posedge clock);
        add_word(32'hDEAD_BEEF);
        flush_req = 1'b1;
        close_frame();
        wait_idle("flush_same_cycle_done", 40);

        // Nine words: first eight form a frame, the ninth waits for a flush.
        for (int i = 0; i < 8; i++) add_word(32'h5000 + 32'(i));
        close_frame();
        add_word(32'h9999_0009);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(posedge clock);
        for (int i = 0; i < 20 && src_q.size() != 0; i++) @(posedge clock);
        flush_req = 1'b1;
        close_frame();
        wait_idle("ninth_word_done", 60);

        // Sequence wrap: preload seq to 0xFFFF, then two one-word frames.
        @(negedge clock);
        force dut.seq = 16'hFFFF;
        @(negedge clock);
        release dut.seq;
        exp_seq = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            add_word(32'hA000_0000 + 32'(k));
            flush_req = 1'b1;
            close_frame();
            wait_idle("seq_wrap_done", 40);
        end

        // Reset mid-payload after header + 3 payload words accepted.
        for (int i = 0; i < 8; i++) add_word(32'hBAD0_0000 + 32'(i));
        close_frame();
        base = xfer_cnt;
        for (int i = 0; i < 60 && xfer_cnt < base + 4; i++) @(posedge clock);
        check_val("reached_mid_pay", 64'(xfer_cnt - base), 64'd4);
        @(posedge clock);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_frame_valid", 64'(frame_valid), 64'd0);
        check_val("midrst_frame_data", 64'(frame_data), 64'd0);
        check_val("midrst_sop_eop", 64'({frame_sop, frame_eop}), 64'd0);
        check_val("midrst_fifo_ack", 64'(fifo_ack), 64'd0);
        exp_q.delete();
        src_q.delete();
        frm.delete();
        hold_valid = 1'b0;
        exp_seq = '0;
        #20 rst = 1'b0;
        for (int i = 0; i < 8; i++) add_word(32'h7700_0000 + 32'(i));
        close_frame();
        check_val("post_rst_hdr_model", 64'(exp_q[0]), 64'h2_A500_0008);
        wait_idle("post_rst_done", 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
